// File: rtl/cell_window_builder_pkg.sv
// Shared types for the cell processing path: pixels, opcodes, 3x3 cells and
// the instruction word handed to the cell processor.
package cell_window_builder_pkg;

    localparam int CELL_DIM    = 3;
    localparam int centerPixel = 1;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        ADDI = 2'd1,
        SUB  = 2'd2,
        SUBI = 2'd3
    } opcode_t;

    // pixelMatrix[0][*] is the oldest row, pixelMatrix[*][0] the oldest column.
    typedef struct packed {
        pixel_t [CELL_DIM-1:0][CELL_DIM-1:0] pixelMatrix;
    } cell_t;

    typedef struct packed {
        opcode_t opcode;
        cell_t   cellA;
        cell_t   cellB;
        pixel_t  userInputA;
    } instruction_t;

endpackage

// File: rtl/cell_window_builder_line_buffer.sv
// Two-row line buffer plus 3x3 shift window for one pixel stream.
// window presents the window as it will be after the current beat, so the
// owner can capture it on the same edge the window itself advances.
module cell_line_buffer
    import cell_window_builder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift,
    input  logic [$clog2(WIDTH)-1:0] col,
    input  pixel_t                   pix,
    output cell_t                    window
);

    pixel_t row1 [WIDTH];
    pixel_t row2 [WIDTH];
    cell_t  win;

    // Next window: drop the oldest column, append {row r-2, row r-1, new pixel}.
    always_comb begin
        window = win;
        for (int i = 0; i < CELL_DIM; i++) begin
            window.pixelMatrix[i][0] = win.pixelMatrix[i][1];
            window.pixelMatrix[i][1] = win.pixelMatrix[i][2];
        end
        window.pixelMatrix[0][2] = row2[col];
        window.pixelMatrix[1][2] = row1[col];
        window.pixelMatrix[2][2] = pix;
    end

    // Row buffers age by one row at this column and the window advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                row1[i] <= '0;
                row2[i] <= '0;
            end
            win <= '0;
        end else if (shift) begin
            row2[col] <= row1[col];
            row1[col] <= pix;
            win       <= window;
        end
    end

endmodule

// File: rtl/cell_window_builder.sv
// Raster-order pixel pair front end: builds 3x3 neighbourhoods for images A
// and B and emits one instruction word per interior pixel.
module cell_window_builder
    import cell_window_builder_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  pixel_t       pixA,
    input  pixel_t       pixB,
    input  opcode_t      cfg_opcode,
    input  pixel_t       cfg_imm,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t IW,
    output logic         frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    opcode_t          frame_op;
    pixel_t           frame_imm;
    cell_t            win_a;
    cell_t            win_b;
    logic             accept;
    logic             emit;
    logic             last_col;
    logic             last_row;
    logic             first_beat;

    // Single output register, so input stalls whenever an unconsumed IW sits there.
    always_comb begin
        in_ready   = !out_valid || out_ready;
        accept     = in_valid && in_ready;
        last_col   = (col == COL_W'(IMG_WIDTH - 1));
        last_row   = (row == ROW_W'(IMG_HEIGHT - 1));
        first_beat = (col == '0) && (row == '0);
        emit       = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    end

    cell_line_buffer #(.WIDTH(IMG_WIDTH)) u_buf_a (
        .clk    (clk),
        .rst    (rst),
        .shift  (accept),
        .col    (col),
        .pix    (pixA),
        .window (win_a)
    );

    cell_line_buffer #(.WIDTH(IMG_WIDTH)) u_buf_b (
        .clk    (clk),
        .rst    (rst),
        .shift  (accept),
        .col    (col),
        .pix    (pixB),
        .window (win_b)
    );

    // Raster position of the next beat; moves only on accepted beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Configuration is frozen for the whole frame at its first beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_op  <= ADD;
            frame_imm <= '0;
        end else if (accept && first_beat) begin
            frame_op  <= cfg_opcode;
            frame_imm <= cfg_imm;
        end
    end

    // Output register: a new emission wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            IW         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (emit) begin
                out_valid     <= 1'b1;
                IW.opcode     <= frame_op;
                IW.cellA      <= win_a;
                IW.cellB      <= win_b;
                IW.userInputA <= frame_imm;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cell_window_builder.md
Name: cell_window_builder

Overview:
- Upstream feeder of the cell processor: accepts raster-order pixel pairs (image A, image B) and forms CELL_DIM x CELL_DIM neighbourhoods via line buffers.
- Emits one instruction_t (opcode, cellA, cellB, userInputA) per interior pixel, under valid/ready handshake on both sides.
- Opcode and immediate are frame-latched configuration.

Parameters:
- IMG_WIDTH, 8, pixels per row (>= 3)
- IMG_HEIGHT, 8, rows per frame (>= 3)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel pair valid
- in_ready  out  1  block can accept a pixel pair this cycle
- pixA  in  pixel_t  image A pixel, raster order
- pixB  in  pixel_t  image B pixel, same position as pixA
- cfg_opcode  in  opcode_t  operation for the next frame
- cfg_imm  in  pixel_t  userInputA for the next frame
- out_valid  out  1  IW valid
- out_ready  in  1  downstream accepts IW
- IW  out  instruction_t  assembled instruction word
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, IW=all zeros, frame_done=0, col=row=0, windows and line buffers cleared. in_ready is combinational and reads 1 after reset.
- Accept rule: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready. Single output register; no skid buffer.
- Position counters: col advances 0..IMG_WIDTH-1 on each accepted beat, then wraps to 0 and row increments. Row wraps to 0 after IMG_HEIGHT-1. Counters do not move on non-accepted cycles.
- Configuration: cfg_opcode and cfg_imm are sampled only on the beat accepted at (0,0). Changes mid-frame have no effect until the next frame.
- Line buffers: per stream, two rows of IMG_WIDTH pixels hold rows r-1 and r-2. Each is read/written at column col on every accepted beat.
- Window: per stream, a 3x3 shift window advances one column per accepted beat using {row r-2, row r-1, new pixel}.
- Window orientation: pixelMatrix[0][*] is the oldest row and [*][0] the oldest column. Centre is [centerPixel][centerPixel] = [1][1].
- Emission: on an accepted beat at (row>=2, col>=2), the next edge loads IW and sets out_valid=1. The centre is at (row-1, col-1).
  - IW.cellA/cellB carry the updated A/B windows.
  - IW.opcode/IW.userInputA carry the frame-latched configuration.
  - Latency: 1 cycle from accepted beat to out_valid.
- Beats with row<2 or col<2 only update buffers and windows and produce no output. Windows never straddle a row wrap, because col<2 suppresses emission.
- Output count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
- out_valid clears on out_ready && out_valid unless a new emission loads in the same cycle; in that case IW is replaced and out_valid stays 1.
- Hold rule: while out_valid && !out_ready, IW is held stable and in_ready=0.
- frame_done: asserted for one cycle on the edge that accepts (IMG_HEIGHT-1, IMG_WIDTH-1). Concurrent with that frame's last out_valid rise.
- Reset mid-frame: all state drops immediately; the next accepted beat is (0,0) of a new frame. A pending IW is discarded.

Decomposition:
- CellProcessingPkg (shared) holds:
  - pixel_t, opcode_t (ADD, ADDI, SUB, SUBI)
  - cell_t with pixelMatrix[CELL_DIM][CELL_DIM]
  - instruction_t
  - CELL_DIM=3 and centerPixel=1
- Sub-module cell_line_buffer, parameterised by WIDTH: two-row storage plus 3x3 shift window for one stream. Instantiated twice (A and B).
- Counters, config latch and the output register stay in the top.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, pixA=row*16+col, pixB=~pixA, out_ready=1, cfg ADD/imm 0:
  - First out_valid follows acceptance of (2,2).
  - cellA centre=0x11, [0][0]=0x00, [2][2]=0x22, cellB centre=0xEE.
  - Exactly 6 outputs, centres 0x11,0x12,0x13,0x21,0x22,0x23.
  - frame_done single pulse.
- Backpressure: hold out_ready=0 for 5 cycles after the first output -> in_ready=0, IW stable, counters frozen. Release -> sequence continues with no loss or duplication.
- Config latch: cfg ADDI/imm 0x07 at (0,0), change to SUB/0x55 at (1,3) -> all 6 frame outputs carry ADDI/0x07. Next frame's outputs carry SUB/0x55.
- Input bubbles: in_valid toggled randomly -> same 6 outputs in order. No output is emitted on non-accepted cycles.
- Reset mid-frame: assert rst low at (2,3) with out_valid=1 -> out_valid=0, IW=0 immediately. A full frame afterwards reproduces scenario 1 exactly.
- Back-to-back frames: two frames without gap -> 12 outputs. The first output of frame 2 is centre (1,1) of frame 2 with no frame-1 pixels in its window. Two frame_done pulses.
